mem_stage_queue: RTL and testbench

Parametrised successor to the single-entry MEM pipeline stage. It holds up to DEPTH in-order instructions between PREMEM and WB, so several loads and stores can wait on the data bus at once instead of stalling on each `data_data_ok`. On a flush it discards every queued instruction and silently absorbs the bus responses still owed to them. Instruction payload is opaque; the block tracks only validity, memory-request state and returned data.

---
 rtl/mem_stage_pkg.sv | 14 +
 rtl/mem_queue_entry_array.sv | 72 +++++++
 rtl/mem_stage_queue.sv | 115 +++++++++++
 tb/tb_mem_stage_queue.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared entry-flag layout and width helpers for the MEM stage queue
package mem_stage_pkg;
    typedef struct packed {
        logic valid;
        logic mem_req;
        logic got;
    } entry_flags_t;
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/mem_queue_entry_array.sv
// mem_queue_entry_array: per-entry flags, read data and payload with tail write, response update, head read
module mem_queue_entry_array
    import mem_stage_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int PAYLOAD_W = 64,
    parameter int DATA_W    = 32,
    parameter int PW        = ptr_w(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic [PW-1:0]        wr_ptr,
    input  logic                 wr_mem_req,
    input  logic [PAYLOAD_W-1:0] wr_payload,
    input  logic                 resp_en,
    input  logic [PW-1:0]        resp_ptr,
    input  logic [DATA_W-1:0]    resp_rdata,
    input  logic                 pop_en,
    input  logic [PW-1:0]        pop_ptr,
    input  logic [PW-1:0]        rd_ptr,
    output logic [DEPTH-1:0]     valid,
    output logic [DEPTH-1:0]     mem_req,
    output logic [DEPTH-1:0]     got,
    output logic [PAYLOAD_W-1:0] rd_payload,
    output logic [DATA_W-1:0]    rd_rdata
);
    entry_flags_t         flags   [DEPTH];
    logic [DATA_W-1:0]    rdata   [DEPTH];
    logic [PAYLOAD_W-1:0] payload [DEPTH];

    // Flush clears everything; a new write beats the pop clear when head and tail alias
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                flags[i]   <= '0;
                rdata[i]   <= '0;
                payload[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) flags[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_en && wr_ptr == PW'(i)) begin
                    flags[i]   <= '{valid: 1'b1, mem_req: wr_mem_req, got: 1'b0};
                    payload[i] <= wr_payload;
                end else if (pop_en && pop_ptr == PW'(i)) begin
                    flags[i] <= '0;
                end else if (resp_en && resp_ptr == PW'(i)) begin
                    flags[i].got <= 1'b1;
                    rdata[i]     <= resp_rdata;
                end
            end
        end
    end

    // Flatten the flags so the control logic can scan all entries
    always_comb begin
        valid   = '0;
        mem_req = '0;
        got     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i]   = flags[i].valid;
            mem_req[i] = flags[i].mem_req;
            got[i]     = flags[i].got;
        end
    end

    assign rd_payload = payload[rd_ptr];
    assign rd_rdata   = rdata[rd_ptr];
endmodule

// File: rtl/mem_stage_queue.sv
// mem_stage_queue: DEPTH-entry in-order MEM stage with outstanding bus responses and flush absorption
module mem_stage_queue
    import mem_stage_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int PAYLOAD_W = 64,
    parameter int DATA_W    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_allowin,
    input  logic                         in_memReq,
    input  logic [PAYLOAD_W-1:0]         in_payload,
    output logic                         out_valid,
    input  logic                         out_allowin,
    output logic [PAYLOAD_W-1:0]         out_payload,
    output logic                         out_memReq,
    output logic [DATA_W-1:0]            out_rdata,
    input  logic                         data_data_ok,
    input  logic [DATA_W-1:0]            data_rdata,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [$clog2(DEPTH+1)-1:0]   discard,
    output logic                         err_spurious
);
    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);

    logic [PW-1:0]        head, tail, resp_ptr, idx;
    logic [DEPTH-1:0]     valid, mem_req, got, pending;
    logic [PAYLOAD_W-1:0] head_payload;
    logic [DATA_W-1:0]    head_rdata;
    logic [CW-1:0]        owed;
    logic [CW:0]          occ;
    logic                 found, resp_drop, resp_live, resp_spur, head_ready, pop, enq;

    mem_queue_entry_array #(
        .DEPTH    (DEPTH),
        .PAYLOAD_W(PAYLOAD_W),
        .DATA_W   (DATA_W),
        .PW       (PW)
    ) u_entries (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .wr_en     (enq),
        .wr_ptr    (tail),
        .wr_mem_req(in_memReq),
        .wr_payload(in_payload),
        .resp_en   (resp_live),
        .resp_ptr  (resp_ptr),
        .resp_rdata(data_rdata),
        .pop_en    (pop),
        .pop_ptr   (head),
        .rd_ptr    (head),
        .valid     (valid),
        .mem_req   (mem_req),
        .got       (got),
        .rd_payload(head_payload),
        .rd_rdata  (head_rdata)
    );

    assign pending = valid & mem_req & ~got;

    // Response pointer is the oldest entry still waiting on data; owed counts all such entries
    always_comb begin
        found    = 1'b0;
        resp_ptr = '0;
        idx      = '0;
        owed     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (!found && pending[idx]) begin
                found    = 1'b1;
                resp_ptr = idx;
            end
            owed = owed + CW'(pending[i]);
        end
    end

    // Route the response, decide head readiness and the enqueue/pop handshakes
    always_comb begin
        resp_drop  = data_data_ok && discard != '0;
        resp_live  = data_data_ok && discard == '0 && found;
        resp_spur  = data_data_ok && discard == '0 && !found;
        head_ready = valid[head] && (!mem_req[head] || got[head] || (resp_live && resp_ptr == head));
        out_valid  = head_ready && !flush;
        pop        = out_valid && out_allowin;
        occ        = {1'b0, count} + {1'b0, discard} - (CW+1)'(pop);
        in_allowin = !flush && occ < (CW+1)'(DEPTH);
        enq        = in_valid && in_allowin;
    end

    assign out_payload = head_payload;
    assign out_memReq  = mem_req[head];
    assign out_rdata   = !valid[head] ? '0 : got[head] ? head_rdata : data_rdata;

    // Pointers and occupancy; a flush converts every still-owed response into discard credit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            discard      <= '0;
            err_spurious <= 1'b0;
        end else begin
            head         <= flush ? '0 : head + PW'(pop);
            tail         <= flush ? '0 : tail + PW'(enq);
            count        <= flush ? '0 : count + CW'(enq) - CW'(pop);
            discard      <= flush ? discard + owed - CW'(resp_drop || resp_live) : discard - CW'(resp_drop);
            err_spurious <= err_spurious | resp_spur;
        end
    end
endmodule

// File: tb/tb_mem_stage_queue.sv
// tb_mem_stage_queue: scenario tasks with a scoreboard of expected pops for mem_stage_queue
module tb_mem_stage_queue;
    localparam int DEPTH = 2;
    localparam int PW_ = 64;
    localparam int DW = 32;
    localparam int CW = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0, in_memReq = 1'b0, out_allowin = 1'b1;
    logic          data_data_ok = 1'b0, flush = 1'b0;
    logic [PW_-1:0] in_payload = '0;
    logic [DW-1:0] data_rdata = '0;
    logic          in_allowin, out_valid, out_memReq, err_spurious;
    logic [PW_-1:0] out_payload;
    logic [DW-1:0] out_rdata;
    logic [CW-1:0] count, discard;

    typedef struct {
        logic [PW_-1:0] payload;
        logic           mem;
        logic [DW-1:0]  rdata;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;
    int vectors = 0;
    int miscompares = 0;

    mem_stage_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PW_), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_allowin  (in_allowin),
        .in_memReq   (in_memReq),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_allowin (out_allowin),
        .out_payload (out_payload),
        .out_memReq  (out_memReq),
        .out_rdata   (out_rdata),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata),
        .flush       (flush),
        .count       (count),
        .discard     (discard),
        .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst && out_valid && out_allowin) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL pop_unexpected: got payload %h, required no pop", out_payload);
            end else begin
                mon_e = sb.pop_front();
                if (out_payload !== mon_e.payload || out_memReq !== mon_e.mem || (mon_e.mem && out_rdata !== mon_e.rdata)) begin
                    miscompares++;
                    $display("FAIL pop_data: got %h/%b/%h, required %h/%b/%h", out_payload, out_memReq, out_rdata,
                             mon_e.payload, mon_e.mem, mon_e.rdata);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({out_valid, in_allowin, err_spurious, out_memReq, count, discard} !== {4'b0100, {CW{1'b0}}, {CW{1'b0}}}) begin
            miscompares++;
            $display("FAIL reset_ctrl: got v=%b a=%b e=%b m=%b c=%0d d=%0d, required 0 1 0 0 0 0",
                     out_valid, in_allowin, err_spurious, out_memReq, count, discard);
        end
        vectors++;
        if (out_payload !== '0 || out_rdata !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h/%h, required 0/0", out_payload, out_rdata);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_memReq = 1'b0;
            in_payload = 64'h1000 + 64'(k);
            sb.push_back('{payload: 64'h1000 + 64'(k), mem: 1'b0, rdata: '0});
            @(negedge clk);
            vectors++;
            if (in_allowin !== 1'b1 || count > 1 || (k > 0 && out_valid !== 1'b1)) begin
                miscompares++;
                $display("FAIL b2b_cycle%0d: got a=%b c=%0d v=%b, required a=1 c<=1 v=%b", k, in_allowin, count, out_valid, k > 0);
            end
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || count !== 1) begin
            miscompares++;
            $display("FAIL b2b_last: got v=%b c=%0d, required 1 1", out_valid, count);
        end
        cyc();
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || count !== 0) begin
            miscompares++;
            $display("FAIL b2b_drain: got v=%b c=%0d, required 0 0", out_valid, count);
        end
        cyc();
    endtask

    task automatic test_loads();
        in_valid = 1'b1;
        in_memReq = 1'b1;
        in_payload = 64'h2001;
        sb.push_back('{payload: 64'h2001, mem: 1'b1, rdata: 32'hAAAA});
        cyc();
        in_payload = 64'h2002;
        sb.push_back('{payload: 64'h2002, mem: 1'b1, rdata: 32'hBBBB});
        @(negedge clk);
        vectors++;
        if (in_allowin !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL load_second: got a=%b v=%b, required 1 0", in_allowin, out_valid);
        end
        cyc();
        in_valid = 1'b0;
        in_memReq = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_allowin !== 1'b0 || out_valid !== 1'b0 || count !== 2) begin
            miscompares++;
            $display("FAIL load_full: got a=%b v=%b c=%0d, required 0 0 2", in_allowin, out_valid, count);
        end
        cyc();
        data_data_ok = 1'b1;
        data_rdata = 32'hAAAA;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1 || in_allowin !== 1'b1) begin
            miscompares++;
            $display("FAIL load_bypass1: got v=%b a=%b, required 1 1", out_valid, in_allowin);
        end
        cyc();
        data_data_ok = 1'b0;
        data_rdata = 32'h0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || count !== 1) begin
            miscompares++;
            $display("FAIL load_wait: got v=%b c=%0d, required 0 1", out_valid, count);
        end
        cyc();
        data_data_ok = 1'b1;
        data_rdata = 32'hBBBB;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL load_bypass2: got v=%b, required 1", out_valid);
        end
        cyc();
        data_data_ok = 1'b0;
        data_rdata = 32'h0;
        @(negedge clk);
        vectors++;
        if (count !== 0) begin
            miscompares++;
            $display("FAIL load_empty: got c=%0d, required 0", count);
        end
        cyc();
    endtask

    task automatic test_full_pass();
        out_allowin = 1'b0;
        in_valid = 1'b1;
        in_memReq = 1'b0;
        in_payload = 64'h3001;
        sb.push_back('{payload: 64'h3001, mem: 1'b0, rdata: '0});
        cyc();
        in_payload = 64'h3002;
        sb.push_back('{payload: 64'h3002, mem: 1'b0, rdata: '0});
        @(negedge clk);
        vectors++;
        if (in_allowin !== 1'b1 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL full_fill: got a=%b v=%b, required 1 1", in_allowin, out_valid);
        end
        cyc();
        in_payload = 64'h3003;
        @(negedge clk);
        vectors++;
        if (in_allowin !== 1'b0 || count !== 2) begin
            miscompares++;
            $display("FAIL full_block: got a=%b c=%0d, required 0 2", in_allowin, count);
        end
        cyc();
        out_allowin = 1'b1;
        sb.push_back('{payload: 64'h3003, mem: 1'b0, rdata: '0});
        @(negedge clk);
        vectors++;
        if (in_allowin !== 1'b1 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL full_passthru: got a=%b v=%b, required 1 1", in_allowin, out_valid);
        end
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (count !== 2) begin
            miscompares++;
            $display("FAIL full_count_kept: got c=%0d, required 2", count);
        end
        cyc();
        cyc();
        @(negedge clk);
        vectors++;
        if (count !== 0) begin
            miscompares++;
            $display("FAIL full_drain: got c=%0d, required 0", count);
        end
        cyc();
    endtask

    task automatic test_flush_outstanding();
        in_valid = 1'b1;
        in_memReq = 1'b1;
        in_payload = 64'h4001;
        cyc();
        in_payload = 64'h4002;
        cyc();
        in_valid = 1'b0;
        in_memReq = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_allowin !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_cycle: got a=%b v=%b, required 0 0", in_allowin, out_valid);
        end
        cyc();
        flush = 1'b0;
        data_data_ok = 1'b1;
        data_rdata = 32'hDEAD;
        @(negedge clk);
        vectors++;
        if (count !== 0 || discard !== 2 || in_allowin !== 1'b0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_after: got c=%0d d=%0d a=%b v=%b, required 0 2 0 0", count, discard, in_allowin, out_valid);
        end
        cyc();
        @(negedge clk);
        vectors++;
        if (discard !== 1 || out_valid !== 1'b0 || in_allowin !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_drop1: got d=%0d v=%b a=%b, required 1 0 1", discard, out_valid, in_allowin);
        end
        cyc();
        data_data_ok = 1'b0;
        data_rdata = 32'h0;
        @(negedge clk);
        vectors++;
        if (discard !== 0 || err_spurious !== 1'b0 || in_allowin !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_drained: got d=%0d e=%b a=%b, required 0 0 1", discard, err_spurious, in_allowin);
        end
        cyc();
    endtask

    task automatic test_flush_with_response();
        in_valid = 1'b1;
        in_memReq = 1'b1;
        in_payload = 64'h5001;
        cyc();
        in_payload = 64'h5002;
        cyc();
        in_valid = 1'b0;
        in_memReq = 1'b0;
        flush = 1'b1;
        data_data_ok = 1'b1;
        data_rdata = 32'h1111;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL flushresp_nopop: got v=%b, required 0", out_valid);
        end
        cyc();
        flush = 1'b0;
        data_data_ok = 1'b0;
        @(negedge clk);
        vectors++;
        if (count !== 0 || discard !== 1) begin
            miscompares++;
            $display("FAIL flushresp_discard: got c=%0d d=%0d, required 0 1", count, discard);
        end
        cyc();
        data_data_ok = 1'b1;
        cyc();
        data_data_ok = 1'b0;
        data_rdata = 32'h0;
        @(negedge clk);
        vectors++;
        if (discard !== 0 || err_spurious !== 1'b0) begin
            miscompares++;
            $display("FAIL flushresp_drain: got d=%0d e=%b, required 0 0", discard, err_spurious);
        end
        cyc();
    endtask

    task automatic test_spurious();
        data_data_ok = 1'b1;
        data_rdata = 32'h5555;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || err_spurious !== 1'b0) begin
            miscompares++;
            $display("FAIL spur_cycle: got v=%b e=%b, required 0 0", out_valid, err_spurious);
        end
        cyc();
        data_data_ok = 1'b0;
        data_rdata = 32'h0;
        @(negedge clk);
        vectors++;
        if (err_spurious !== 1'b1) begin
            miscompares++;
            $display("FAIL spur_set: got e=%b, required 1", err_spurious);
        end
        repeat (3) cyc();
        @(negedge clk);
        vectors++;
        if (err_spurious !== 1'b1) begin
            miscompares++;
            $display("FAIL spur_sticky: got e=%b, required 1", err_spurious);
        end
        cyc();
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1;
        in_memReq = 1'b1;
        in_payload = 64'h6001;
        cyc();
        in_payload = 64'h6002;
        cyc();
        in_valid = 1'b0;
        in_memReq = 1'b0;
        flush = 1'b1;
        data_data_ok = 1'b1;
        data_rdata = 32'h2222;
        cyc();
        flush = 1'b0;
        data_data_ok = 1'b0;
        data_rdata = 32'h0;
        out_allowin = 1'b0;
        in_valid = 1'b1;
        in_payload = 64'h6003;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (count !== 1 || discard !== 1 || out_valid !== 1'b1 || in_allowin !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_pre: got c=%0d d=%0d v=%b a=%b, required 1 1 1 0", count, discard, out_valid, in_allowin);
        end
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({out_valid, in_allowin, err_spurious, out_memReq, count, discard} !== {4'b0100, {CW{1'b0}}, {CW{1'b0}}}) begin
            miscompares++;
            $display("FAIL areset_ctrl: got v=%b a=%b e=%b m=%b c=%0d d=%0d, required 0 1 0 0 0 0",
                     out_valid, in_allowin, err_spurious, out_memReq, count, discard);
        end
        vectors++;
        if (out_payload !== '0 || out_rdata !== '0) begin
            miscompares++;
            $display("FAIL areset_data: got %h/%h, required 0/0", out_payload, out_rdata);
        end
        out_allowin = 1'b1;
        cyc();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_allowin !== 1'b1 || count !== 0 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_after: got a=%b c=%0d v=%b, required 1 0 0", in_allowin, count, out_valid);
        end
        cyc();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_loads();
        test_full_pass();
        test_flush_outstanding();
        test_flush_with_response();
        test_spurious();
        test_async_reset();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_leftover: got %0d pending, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
